// File: rtl/duck_pkg.sv
// Shared constants and types for the duck-hunt shot path.
package duck_pkg;
  localparam int COORD_W   = 10;
  localparam int SCORE_MAX = 999;
  localparam int SPAWN_Y   = 424;
  localparam int EXT_W     = 12;

  typedef enum logic [1:0] {SCAN, KILL, COOLDOWN} hit_state_e;

  typedef struct packed {
    logic               bullet_valid;
    logic               duck_alive;
    logic [2:0]         idx;
    logic [COORD_W-1:0] bx;
    logic [COORD_W-1:0] by;
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
  } shot_stage_t;
endpackage

// File: rtl/score_counter.sv
// Saturating hit counter; 3-digit BCD when SHOT_SCORE_BCD_EN is defined, binary otherwise.
module score_counter import duck_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [11:0] score
);
`ifdef SHOT_SCORE_BCD_EN
  logic [3:0] d2, d1, d0;
  logic       at_max;

  assign at_max = (d2 == 4'(SCORE_MAX / 100)) && (d1 == 4'((SCORE_MAX / 10) % 10)) &&
                  (d0 == 4'(SCORE_MAX % 10));

  always_ff @(posedge clk) begin
    if (reset) begin
      d2 <= '0;
      d1 <= '0;
      d0 <= '0;
    end else if (inc && !at_max) begin
      if (d0 == 4'd9) begin
        d0 <= '0;
        if (d1 == 4'd9) begin
          d1 <= '0;
          d2 <= d2 + 4'd1;
        end else begin
          d1 <= d1 + 4'd1;
        end
      end else begin
        d0 <= d0 + 4'd1;
      end
    end
  end

  assign score = {d2, d1, d0};
`else
  logic [9:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)                              cnt <= '0;
    else if (inc && cnt != 10'(SCORE_MAX))  cnt <= cnt + 10'd1;
  end

  assign score = {2'b00, cnt};
`endif
endmodule

// File: rtl/shot_hit_detector.sv
// Bullet/duck overlap detector with kill handshake and post-kill cooldown.
// Score format selected by SHOT_SCORE_BCD_EN (see score_counter).
module shot_hit_detector import duck_pkg::*; #(
  parameter int DUCK_W          = 32,
  parameter int DUCK_H          = 32,
  parameter int BULLET_W        = 2,
  parameter int COOLDOWN_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [COORD_W-1:0]        bullet_x,
  input  logic signed [COORD_W-1:0] bullet_y,
  input  logic                      bullet_valid,
  input  logic [2:0]                bullet_idx,
  input  logic [COORD_W-1:0]        duck_x,
  input  logic [COORD_W-1:0]        duck_y,
  input  logic                      duck_alive,
  output logic                      kill_valid,
  output logic [2:0]                kill_idx,
  input  logic                      kill_ready,
  output logic                      hit,
  output logic                      duck_hit,
  output logic [11:0]               score
);
  localparam int CNT_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic signed [EXT_W-1:0] BW_E = EXT_W'(BULLET_W);
  localparam logic signed [EXT_W-1:0] DW_E = EXT_W'(DUCK_W);
  localparam logic signed [EXT_W-1:0] DH_E = EXT_W'(DUCK_H);

  shot_stage_t s1;
  hit_state_e  state;
  logic [CNT_W-1:0] cnt;
  logic signed [EXT_W-1:0] bx, by, dx, dy;
  logic ov, score_inc;

  // Stage 1: snapshot of everything the overlap test needs.
  always_ff @(posedge clk) begin
    if (reset) s1 <= '0;
    else       s1 <= '{bullet_valid: bullet_valid, duck_alive: duck_alive, idx: bullet_idx,
                       bx: bullet_x, by: bullet_y, dx: duck_x, dy: duck_y};
  end

  // Widen to 12 bits so a bullet above the screen top never wraps into range.
  assign bx = $signed({2'b00, s1.bx});
  assign by = {{2{s1.by[COORD_W-1]}}, s1.by};
  assign dx = $signed({2'b00, s1.dx});
  assign dy = $signed({2'b00, s1.dy});

  assign ov = s1.bullet_valid & s1.duck_alive & (bx + BW_E > dx) & (bx < dx + DW_E) &
              (by >= dy) & (by < dy + DH_E);

  assign score_inc = (state == SCAN) & ov;
  assign duck_hit  = (state != SCAN);

  // Stage 2: the overlap result lands directly in the FSM registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SCAN;
      kill_valid <= 1'b0;
      kill_idx   <= '0;
      hit        <= 1'b0;
      cnt        <= '0;
    end else begin
      hit <= 1'b0;
      case (state)
        SCAN: if (ov) begin
          state      <= KILL;
          hit        <= 1'b1;
          kill_valid <= 1'b1;
          kill_idx   <= s1.idx;
        end
        KILL: if (kill_ready) begin
          state      <= COOLDOWN;
          kill_valid <= 1'b0;
          cnt        <= CNT_LOAD;
        end
        COOLDOWN: begin
          if (cnt == '0) state <= SCAN;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= SCAN;
      endcase
    end
  end

  score_counter u_score (
    .clk   (clk),
    .reset (reset),
    .inc   (score_inc),
    .score (score)
  );
endmodule

// File: tb/tb_shot_hit_detector.sv
// Randomized + directed bench for shot_hit_detector against a cycle-count reference model.
module tb_shot_hit_detector;
  localparam int DW = 32, DH = 32, BW = 2, CD = 8;

  logic clk = 1'b0;
  logic reset;
  logic [9:0] bullet_x, duck_x, duck_y;
  logic signed [9:0] bullet_y;
  logic bullet_valid, duck_alive, kill_ready;
  logic [2:0] bullet_idx;
  logic kill_valid, hit, duck_hit;
  logic [2:0] kill_idx;
  logic [11:0] score;

  int checks = 0, failures = 0;

  // Reference model: mode 0 idle, 1 waiting for ack, 2 cooling down with m_left cycles to go.
  int m_mode = 0, m_left = 0, m_score = 0, m_kidx = 0;
  bit m_hit = 0, pend_ov = 0;
  int pend_idx = 0;

  shot_hit_detector #(.DUCK_W(DW), .DUCK_H(DH), .BULLET_W(BW), .COOLDOWN_CYCLES(CD)) dut (
    .clk(clk), .reset(reset), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_valid(bullet_valid), .bullet_idx(bullet_idx), .duck_x(duck_x), .duck_y(duck_y),
    .duck_alive(duck_alive), .kill_valid(kill_valid), .kill_idx(kill_idx),
    .kill_ready(kill_ready), .hit(hit), .duck_hit(duck_hit), .score(score)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] exp_score(int s);
`ifdef SHOT_SCORE_BCD_EN
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
`else
    return 12'(s);
`endif
  endfunction

  function automatic bit ref_overlap(int bx, int by, int dx, int dy, bit v, bit a);
    return v && a && (bx + BW > dx) && (bx < dx + DW) && (by >= dy) && (by < dy + DH);
  endfunction

  function automatic logic [18:0] exp_vec();
    return {m_hit, m_mode == 1, 3'(m_kidx), m_mode != 0, exp_score(m_score)};
  endfunction

  // One clock: advance the model on the same edge the DUT sees, then settle.
  task automatic step();
    bit ov_now = ref_overlap(int'(bullet_x), int'(bullet_y), int'(duck_x), int'(duck_y),
                             bullet_valid, duck_alive);
    int idx_now = int'(bullet_idx);
    bit rdy = kill_ready, rst = reset;
    @(posedge clk);
    m_hit = 0;
    if (rst) begin
      m_mode = 0; m_left = 0; m_score = 0; m_kidx = 0; pend_ov = 0; pend_idx = 0;
    end else begin
      case (m_mode)
        0: if (pend_ov) begin
          m_mode = 1; m_hit = 1; m_kidx = pend_idx;
          if (m_score < 999) m_score++;
        end
        1: if (rdy) begin m_mode = 2; m_left = CD; end
        default: begin m_left--; if (m_left == 0) m_mode = 0; end
      endcase
      pend_ov = ov_now; pend_idx = idx_now;
    end
    #1;
  endtask

  task automatic shoot(int bx, int by, int idx, bit v);
    bullet_x = 10'(bx); bullet_y = 10'(by); bullet_idx = 3'(idx); bullet_valid = v;
  endtask

  task automatic drain();
    bullet_valid = 0; kill_ready = 1;
    for (int k = 0; k < 4 * CD + 10 && m_mode != 0; k++) step();
    step(); step();
  endtask

  task automatic test_reset();
    reset = 1; kill_ready = 0; duck_alive = 1; duck_x = 90; duck_y = 40;
    shoot(100, 50, 3, 1);
    step(); step();
    checks++;
    if ({hit, kill_valid, kill_idx, duck_hit, score} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {hit, kill_valid, kill_idx, duck_hit, score});
    end
    reset = 0; bullet_valid = 0; step(); step();
  endtask

  task automatic test_basic_hit();
    duck_x = 90; duck_y = 40; duck_alive = 1; kill_ready = 0;
    shoot(100, 50, 3, 1); step();
    checks++;
    if (hit !== 1'b0) begin failures++; $display("FAIL basic_hit_early got=%b exp=0", hit); end
    bullet_valid = 0; step();
    checks++;
    if ({hit, kill_valid, kill_idx, score} !== {1'b1, 1'b1, 3'd3, exp_score(1)}) begin
      failures++;
      $display("FAIL basic_hit got=%b/%b/%0d/%h exp=1/1/3/%h", hit, kill_valid, kill_idx, score,
               exp_score(1));
    end
    drain();
  endtask

  task automatic test_edge();
    int sc = m_score;
    duck_x = 90; duck_y = 40; kill_ready = 0;
    shoot(88, 50, 1, 1); step(); bullet_valid = 0; step();
    checks++;
    if ({hit, kill_valid, score} !== {1'b0, 1'b0, exp_score(sc)}) begin
      failures++; $display("FAIL edge_x88 got=%b/%b/%h exp=0/0/%h", hit, kill_valid, score, exp_score(sc));
    end
    shoot(89, 50, 2, 1); step(); bullet_valid = 0; step();
    checks++;
    if ({hit, kill_idx, score} !== {1'b1, 3'd2, exp_score(sc + 1)}) begin
      failures++; $display("FAIL edge_x89 got=%b/%0d/%h exp=1/2/%h", hit, kill_idx, score, exp_score(sc + 1));
    end
    drain();
  endtask

  task automatic test_handshake();
    int cnt = 0;
    kill_ready = 0; duck_x = 200; duck_y = 100;
    shoot(210, 110, 5, 1); step(); bullet_valid = 0; step();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({kill_valid, kill_idx, duck_hit} !== {1'b1, 3'd5, 1'b1}) begin
        failures++; $display("FAIL hold_cycle%0d got=%b/%0d/%b exp=1/5/1", k, kill_valid, kill_idx, duck_hit);
      end
      if (k < 4) step();
    end
    duck_alive = 0;
    kill_ready = 1; step(); kill_ready = 0;
    checks++;
    if (kill_valid !== 1'b0) begin failures++; $display("FAIL ack_drop got=%b exp=0", kill_valid); end
    for (int k = 0; k < CD + 10 && duck_hit === 1'b1; k++) begin cnt++; step(); end
    checks++;
    if (cnt != CD) begin failures++; $display("FAIL cooldown_len got=%0d exp=%0d", cnt, CD); end
    duck_alive = 1;
    drain();
  endtask

  task automatic test_cooldown_ignore();
    int sc = m_score + 1;
    kill_ready = 1; duck_x = 300; duck_y = 200;
    shoot(305, 205, 4, 1); step(); bullet_valid = 0; step();
    checks++;
    if ({hit, kill_valid} !== 2'b11) begin failures++; $display("FAIL ready_first got=%b%b exp=11", hit, kill_valid); end
    step();
    checks++;
    if (kill_valid !== 1'b0) begin failures++; $display("FAIL ready_first_ack got=%b exp=0", kill_valid); end
    shoot(305, 205, 6, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({hit, score} !== {1'b0, exp_score(sc)}) begin
        failures++; $display("FAIL cooldown_ignore got=%b/%h exp=0/%h", hit, score, exp_score(sc));
      end
    end
    drain();
  endtask

  task automatic test_neg_y();
    int sc = m_score;
    duck_x = 90; kill_ready = 0;
    duck_y = 0;    shoot(100, -5, 1, 1);  step(); bullet_valid = 0; step();
    checks++;
    if ({hit, score} !== {1'b0, exp_score(sc)}) begin failures++; $display("FAIL neg_y_top got=%b/%h exp=0", hit, score); end
    duck_y = 1000; shoot(100, -11, 1, 1); step(); bullet_valid = 0; step();
    checks++;
    if ({hit, score} !== {1'b0, exp_score(sc)}) begin failures++; $display("FAIL neg_y_wrap got=%b/%h exp=0", hit, score); end
    drain();
  endtask

  task automatic test_reset_in_kill();
    kill_ready = 0; duck_x = 90; duck_y = 40;
    shoot(100, 50, 7, 1); step(); bullet_valid = 0; step();
    reset = 1; step(); reset = 0;
    checks++;
    if ({kill_valid, duck_hit, hit, score} !== {3'b000, 12'd0}) begin
      failures++; $display("FAIL reset_in_kill got=%b%b%b/%h exp=000/0", kill_valid, duck_hit, hit, score);
    end
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      int by;
      if (n % 50 == 0) begin duck_x = 10'($urandom_range(40, 900)); duck_y = 10'($urandom_range(0, 100)); end
      duck_alive = ($urandom_range(0, 7) != 0);
      by = int'(duck_y) + int'($urandom_range(0, 80)) - 40;
      if (by < -11) by = -11;
      shoot(int'(duck_x) + int'($urandom_range(0, 80)) - 40, by, int'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0);
      kill_ready = $urandom_range(0, 2) == 0;
      reset = ($urandom_range(0, 299) == 0);
      step();
      checks++;
      if ({hit, kill_valid, kill_idx, duck_hit, score} !== exp_vec()) begin
        failures++;
        $display("FAIL random_cycle%0d got=%h exp=%h", n, {hit, kill_valid, kill_idx, duck_hit, score}, exp_vec());
      end
    end
    reset = 0; duck_alive = 1; drain();
  endtask

  task automatic test_saturation();
    reset = 1; step(); reset = 0;
    duck_x = 90; duck_y = 40; kill_ready = 1;
    for (int n = 0; n < 1100 && m_score < 999; n++) begin
      shoot(100, 50, 2, 1); step(); bullet_valid = 0; step();
      for (int k = 0; k < CD + 6 && m_mode != 0; k++) step();
    end
    checks++;
    if (score !== exp_score(999)) begin failures++; $display("FAIL preload_999 got=%h exp=%h", score, exp_score(999)); end
    kill_ready = 0;
    shoot(100, 50, 6, 1); step(); bullet_valid = 0; step();
    checks++;
    if ({hit, kill_valid, kill_idx, score} !== {1'b1, 1'b1, 3'd6, exp_score(999)}) begin
      failures++; $display("FAIL saturate got=%b/%b/%0d/%h exp=1/1/6/%h", hit, kill_valid, kill_idx, score, exp_score(999));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_edge();
    test_handshake();
    test_cooldown_ignore();
    test_neg_y();
    test_reset_in_kill();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
